// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

   // Returned in place of a real instruction for misaligned or out-of-range fetches
   localparam logic [31:0] NOP_INSTR  = 32'h00000000;
   localparam int          WORD_BYTES = 4;

   // One buffered response as seen by the fetch consumer
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        error;
   } rsp_entry_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Small synchronous response FIFO; head is always presented combinationally.
module imem_rsp_fifo
   import imem_pkg::*;
#(
   parameter  int DEPTH = 3,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  rsp_entry_t    i_push_data,
   input  logic          i_pop,
   output rsp_entry_t    o_head,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   rsp_entry_t    r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   // Pointers wrap at DEPTH, which need not be a power of two
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Entry storage; contents are meaningless until pushed, so no reset
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wptr] <= i_push_data;
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= ptr_inc(r_wptr);
         if (i_pop)  r_rptr <= ptr_inc(r_rptr);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: word RAM, address decode, fixed-latency read
// pipeline, credit-limited request acceptance and an in-order response FIFO.
module imem_responder
   import imem_pkg::*;
#(
   parameter  int DEPTH_WORDS = 256,
   parameter  int LATENCY     = 2,
   localparam int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [31:0]   req_addr,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_instr,
   output logic [31:0]   rsp_addr,
   output logic          rsp_error,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   output logic          busy
);

   localparam int            BW      = $clog2(WORD_BYTES);
   localparam int            FDEPTH  = LATENCY + 1;
   localparam int            CW      = $clog2(FDEPTH + 1);
   // One credit per FIFO slot: every accepted request is guaranteed a place
   localparam logic [CW-1:0] CREDITS = CW'(FDEPTH);

   logic [31:0]      r_mem [DEPTH_WORDS];
   logic [LATENCY:1] r_vld_pipe;
   rsp_entry_t       r_pipe [1:LATENCY];
   logic [CW-1:0]    r_out;
   rsp_entry_t       r_last;

   logic [AW-1:0]    w_idx;
   logic             w_err;
   logic             w_acc;
   logic             w_pop;
   logic             w_empty;
   rsp_entry_t       w_head;
   rsp_entry_t       w_rsp;
   logic [CW-1:0]    w_fifo_cnt;

   // Decode: word index from the byte address, error on misalignment or range
   assign w_idx = req_addr[AW+BW-1:BW];
   assign w_err = (req_addr[BW-1:0] != '0) || (req_addr[31:AW+BW] != '0);

   // Acceptance depends only on registered credit state, never on rsp_ready
   assign req_ready = !reset && !load_en && (r_out < CREDITS);
   assign w_acc     = req_valid && req_ready;
   assign w_pop     = rsp_valid && rsp_ready;

   // Program load and stage-1 read, then payload shift through the pipeline
   always_ff @(posedge clk) begin
      if (load_en) r_mem[load_addr] <= load_data;
      if (w_acc)
         r_pipe[1] <= '{addr:  req_addr,
                        instr: w_err ? NOP_INSTR : r_mem[w_idx],
                        error: w_err};
      for (int k = LATENCY; k >= 2; k--) r_pipe[k] <= r_pipe[k-1];
   end

   // Stage valids; reset drops every in-flight request
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vld_pipe <= '0;
      end else begin
         r_vld_pipe[1] <= w_acc;
         for (int k = 2; k <= LATENCY; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
      end
   end

   // Outstanding count: pipeline plus FIFO occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out <= '0;
      end else begin
         case ({w_acc, w_pop})
            2'b10:   r_out <= r_out + 1'b1;
            2'b01:   r_out <= r_out - 1'b1;
            default: r_out <= r_out;
         endcase
      end
   end

   imem_rsp_fifo #(.DEPTH(FDEPTH)) u_fifo (
      .i_clk       (clk),
      .i_rst       (reset),
      .i_push      (r_vld_pipe[LATENCY]),
      .i_push_data (r_pipe[LATENCY]),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_empty     (w_empty),
      .o_count     (w_fifo_cnt)
   );

   // Remember the last presented response so outputs hold while the FIFO is empty
   always_ff @(posedge clk or posedge reset) begin
      if (reset)         r_last <= '0;
      else if (!w_empty) r_last <= w_head;
   end

   // FIFO occupancy can never exceed the outstanding count
   always_ff @(posedge clk) begin
      if (!reset) assert (w_fifo_cnt <= r_out);
   end

   assign w_rsp     = w_empty ? r_last : w_head;
   assign rsp_valid = !w_empty;
   assign rsp_instr = w_rsp.instr;
   assign rsp_addr  = w_rsp.addr;
   assign rsp_error = w_rsp.error;
   assign busy      = (r_out != '0);

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder at the far end of the fetch path: accepts word addresses from the program counter and returns instruction words.
- Synchronous word-addressed RAM with a configurable read pipeline and a valid/ready request/response handshake.
- Response buffer absorbs backpressure, so no request is ever lost.
- Separate load port writes program contents before or between fetches.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two, 16..4096.
- LATENCY, 2: cycles from request accept to response valid; legal range 1..4.
- AW, $clog2(DEPTH_WORDS): word-index width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request accepted when req_valid && req_ready at posedge.
- req_addr  in  32  byte address from PC.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response when rsp_valid && rsp_ready.
- rsp_instr  out  32  instruction word.
- rsp_addr  out  32  echo of the request address.
- rsp_error  out  1  address misaligned or out of range.
- load_en  in  1  program-load write strobe.
- load_addr  in  AW  word index to write.
- load_data  in  32  word to write.
- busy  out  1  one or more requests outstanding.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on port reset.
- State cleared by reset:
  - all pipeline-stage valids, FIFO pointers/count and the outstanding counter are cleared;
  - rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_error=0, busy=0;
  - req_ready=0 while reset is asserted.
  - Memory contents are not reset.
- Reset mid-operation: all in-flight and buffered responses are discarded. No response for them appears after reset deasserts.
- Address decode:
  - index = req_addr[AW+1:2].
  - Error if req_addr[1:0]!=0 or req_addr[31:AW+2]!=0.
  - An erroring request still consumes a slot and returns rsp_error=1, rsp_instr=32'h00000000 (NOP_INSTR). Memory is not read.
- Pipeline: an accepted request enters a LATENCY-stage shift pipeline carrying {valid, addr, error, data}. The RAM read occurs in stage 1.
- Output buffer: at stage LATENCY the entry is pushed into the response FIFO of depth LATENCY+1. rsp_* always present the FIFO head.
- Ordering: responses are strictly in request order.
- Flow control:
  - outstanding = in-pipeline entries + FIFO entries. It is +1 on accept and -1 on response handshake; both in the same cycle leave it unchanged.
  - req_ready = !reset && !load_en && (outstanding < LATENCY+1). It is a registered-count function and has no combinational path from rsp_ready.
  - With rsp_ready held high, sustained throughput is 1 request per cycle and first response latency is exactly LATENCY cycles after accept.
- Backpressure: with rsp_ready=0, exactly LATENCY+1 requests are accepted, then req_ready=0 until a response handshake occurs. The FIFO never overflows; pushes are guaranteed by the credit count.
- Empty FIFO: rsp_valid=0. rsp_instr/rsp_addr/rsp_error hold their last values and must not be sampled.
- Load:
  - load_en=1 writes load_data to mem[load_addr] at posedge, and forces req_ready=0 that cycle.
  - A request accepted in the following cycle reads the new data.
  - A load never corrupts requests already in flight: their stage-1 read completed before the load, or the load blocked their accept.
- busy = (outstanding != 0).

Decomposition:
- Shared package imem_pkg:
  - NOP_INSTR = 32'h00000000;
  - WORD_BYTES = 4;
  - response-entry struct {addr[31:0], instr[31:0], error}.
- Sub-module imem_rsp_fifo: synchronous FIFO, parameter DEPTH=LATENCY+1, asynchronous active-high reset clearing pointers and count, outputs head/empty/count.
- Top level holds the RAM, decode, pipeline and credit counter.

Test Plan:
1. Reset; load mem[0..3]=32'h20080005, 32'h20090007, 32'h01095020, 32'hAC0A0000. Hold rsp_ready=1 and issue addresses 0x0, 0x4, 0x8, 0xC on consecutive cycles. -> Responses appear 2 cycles after each accept, one per cycle, in order, with matching rsp_addr and rsp_error=0.
2. Request 0x00000002, then 0x00000400 (DEPTH=256). -> Two responses, each rsp_error=1, rsp_instr=0x00000000, rsp_addr echoed.
3. rsp_ready=0 with req_valid held on 0x0, 0x4, 0x8, 0xC. -> Exactly 3 accepts, then req_ready=0 and busy=1. Raise rsp_ready -> 0x0, 0x4, 0x8 delivered in order, then 0xC is accepted.
4. load_en=1 (addr 1, data 32'hDEADBEEF) with req_valid=1 on 0x4 in the same cycle. -> req_ready=0 that cycle. Request accepted next cycle returns 32'hDEADBEEF.
5. Two requests outstanding, then assert reset asynchronously between clock edges. -> rsp_valid, busy and req_ready drop to 0 immediately. After release, no stale responses appear and a new request to 0x0 returns the loaded contents.
